rf_op_sequencer: RTL and testbench
==================================

Name: rf_op_sequencer

Overview:
- Micro-op controller for the 16-entry register file, which has 2 read ports and 1 write port.
- Accepts one 16-bit instruction at a time on a valid/ready handshake.
- Drives the register file's read addresses and captures the read data.
- Computes a DW-bit ALU result and performs the write-back, so the switch/LED front end no longer sequences register-file accesses by hand.

Parameters:
- DW, 4, register data width.
- AW, 4, register address width (file depth 2**AW).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_instr  input  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm.
- in_ready  output  1  sequencer can accept an instruction.
- rf_rr1  output  AW  register-file read address, port 1.
- rf_rr2  output  AW  register-file read address, port 2.
- rf_rd1  input  DW  port-1 read data; valid one cycle after the address is registered at a clock edge.
- rf_rd2  input  DW  port-2 read data; same timing as rf_rd1.
- rf_we  output  1  write enable.
- rf_wr  output  AW  write address.
- rf_wdata  output  DW  write data.
- done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  one-cycle pulse when an illegal opcode retires.
- carry  output  1  sticky carry/borrow from the last ADD or SUB.

Behaviour:
- Reset (asynchronous, immediate):
  - state goes to IDLE.
  - in_ready=1; rf_we=0, done=0, err=0, carry=0.
  - rf_rr1, rf_rr2, rf_wr and rf_wdata all =0.
  - Latched instruction and result registers are cleared.
- States: IDLE -> RD -> EX -> WB -> IDLE. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: latch in_instr, load rf_rr1=rs1 and rf_rr2=rs2, go to RD. in_ready=0 after E0.
- RD: one cycle while the register file registers its read addresses at E1. Go to EX.
- EX: at E2, sample rf_rd1 (A) and rf_rd2 (B), compute the result into rf_wdata, load rf_wr=rd, go to WB. Opcodes:
  - 0 NOP: no write.
  - 1 ADD: A+B mod 2**DW; carry=bit DW of the sum.
  - 2 SUB: A-B mod 2**DW; carry=1 when A<B (borrow).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 MOV: result=A.
  - 7 LDI: result=zero-extended imm field [3:0]; read data ignored.
  - 8 SHL: A<<1, carry=A[DW-1].
  - 9 SHR: A>>1 logical, carry=A[0].
  - 10..15: illegal; no write.
- carry changes only on ADD, SUB, SHL and SHR.
- WB (one cycle):
  - rf_we=1 except for NOP and illegal opcodes.
  - done=1; err=1 for an illegal opcode.
  - At E3 go to IDLE; rf_we, done and err drop to 0 after E3.
- Latency and throughput: accept to done = 3 cycles (done high in the cycle after E2); one instruction per 4 cycles.
- in_valid held while in_ready=0: ignored, nothing latched. The producer must hold in_instr until the handshake.
- rd equal to rs1 or rs2: legal. Reads complete before the write, so old values are used.
- Reset asserted mid-instruction:
  - the instruction is abandoned and no write occurs.
  - rf_we deasserts asynchronously with reset.
- Changes to in_instr after acceptance have no effect.

Optional Feature:
- Macro: RFSEQ_LDI_FAST_EN.
- Defined: LDI skips RD and EX. At accept (E0) the sequencer loads rf_wdata=imm and rf_wr=rd and goes straight to WB. done is high the cycle after E0; throughput is 1 LDI per 2 cycles. Other opcodes are unchanged.
- Undefined: LDI takes the full 4-state path.

Test Plan:
- Reset, then LDI r3,#9 (0x7309) -> rf_we=1, rf_wr=3, rf_wdata=9 with done=1 three cycles after accept; carry=0.
- Model file r1=0xC, r2=0x7; ADD r4,r1,r2 (0x1412) -> rf_wdata=0x3, carry=1. Then SUB r5,r2,r1 (0x2521) -> rf_wdata=0xB, carry=1.
- Opcode 0xE (0xE000) -> rf_we stays 0, done=1 and err=1 together; NOP 0x0000 -> done=1, err=0, rf_we=0.
- Back-to-back in_valid held high with two instructions -> in_ready low for 3 cycles; the second is accepted on the edge after WB; 8 cycles total for both.
- Reset pulsed while in EX of ADD -> rf_we never asserts, in_ready=1 immediately, carry=0.
- With RFSEQ_LDI_FAST_EN, LDI r0,#15 -> rf_we=1 and done=1 in the cycle after accept; ADD latency unchanged at 3.

Source files
------------

// File: rtl/rf_op_sequencer_if.sv
// Instruction handshake and register-file access bundle for rf_op_sequencer.
// slave: the sequencer; master: the instruction producer together with the register file.
interface rf_op_sequencer_if #(
    parameter int DW = 4,
    parameter int AW = 4
);
    logic          in_valid;
    logic [15:0]   in_instr;
    logic          in_ready;
    logic [AW-1:0] rf_rr1;
    logic [AW-1:0] rf_rr2;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic          rf_we;
    logic [AW-1:0] rf_wr;
    logic [DW-1:0] rf_wdata;
    logic          done;
    logic          err;
    logic          carry;

    modport master (
        output in_valid, in_instr, rf_rd1, rf_rd2,
        input  in_ready, rf_rr1, rf_rr2, rf_we, rf_wr, rf_wdata, done, err, carry
    );

    modport slave (
        input  in_valid, in_instr, rf_rd1, rf_rd2,
        output in_ready, rf_rr1, rf_rr2, rf_we, rf_wr, rf_wdata, done, err, carry
    );
endinterface

// File: rtl/rf_op_sequencer.sv
// Micro-op sequencer: read two registers, run a DW-bit ALU op, write the result back.
// Optional RFSEQ_LDI_FAST_EN: LDI jumps from accept straight to write-back.
//
// state | meaning
// IDLE  | in_ready high, waiting for an instruction
// RD    | register file is registering the read addresses
// EX    | read data valid; ALU result, write address and carry captured
// WB    | rf_we/done/err presented for one cycle
module rf_op_sequencer #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input logic            clk,
    input logic            reset,
    rf_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    state_t        state;
    logic [3:0]    op_q;
    logic [3:0]    rd_q;
    logic [3:0]    imm_q;
    logic          in_ready_q;
    logic [AW-1:0] rr1_q;
    logic [AW-1:0] rr2_q;
    logic          we_q;
    logic [AW-1:0] wr_q;
    logic [DW-1:0] wdata_q;
    logic          done_q;
    logic          err_q;
    logic          carry_q;

    logic [3:0] in_op;
    logic [3:0] in_rd;
    logic [3:0] in_rs1;
    logic [3:0] in_rs2;
    logic       accept;

    assign in_op  = bus.in_instr[15:12];
    assign in_rd  = bus.in_instr[11:8];
    assign in_rs1 = bus.in_instr[7:4];
    assign in_rs2 = bus.in_instr[3:0];
    assign accept = bus.in_valid && in_ready_q;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic          alu_we;
    logic          alu_err;

    // A (DW+1)-bit difference wraps into bit DW exactly when A < B, giving the borrow.
    always_comb begin
        op_a      = bus.rf_rd1;
        op_b      = bus.rf_rd2;
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = '0;
        alu_carry = carry_q;
        alu_we    = 1'b1;
        alu_err   = 1'b0;
        case (op_q)
            OP_NOP: alu_we = 1'b0;
            OP_ADD: begin
                alu_res   = sum[DW-1:0];
                alu_carry = sum[DW];
            end
            OP_SUB: begin
                alu_res   = diff[DW-1:0];
                alu_carry = diff[DW];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_MOV: alu_res = op_a;
            OP_LDI: alu_res = DW'(imm_q);
            OP_SHL: begin
                alu_res   = op_a << 1;
                alu_carry = op_a[DW-1];
            end
            OP_SHR: begin
                alu_res   = op_a >> 1;
                alu_carry = op_a[0];
            end
            default: begin
                alu_we  = 1'b0;
                alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            in_ready_q <= 1'b1;
            rr1_q      <= '0;
            rr2_q      <= '0;
            we_q       <= 1'b0;
            wr_q       <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= in_op;
                        rd_q       <= in_rd;
                        imm_q      <= in_rs2;
                        rr1_q      <= AW'(in_rs1);
                        rr2_q      <= AW'(in_rs2);
                        in_ready_q <= 1'b0;
`ifdef RFSEQ_LDI_FAST_EN
                        // The immediate needs no register read, so write it back directly.
                        if (in_op == OP_LDI) begin
                            wdata_q <= DW'(in_rs2);
                            wr_q    <= AW'(in_rd);
                            we_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= WB;
                        end else begin
                            state <= RD;
                        end
`else
                        state <= RD;
`endif
                    end
                end
                RD: state <= EX;
                EX: begin
                    wdata_q <= alu_res;
                    wr_q    <= AW'(rd_q);
                    we_q    <= alu_we;
                    done_q  <= 1'b1;
                    err_q   <= alu_err;
                    carry_q <= alu_carry;
                    state   <= WB;
                end
                WB: begin
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.rf_rr1   = rr1_q;
    assign bus.rf_rr2   = rr2_q;
    assign bus.rf_we    = we_q;
    assign bus.rf_wr    = wr_q;
    assign bus.rf_wdata = wdata_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.carry    = carry_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Self-checking bench for rf_op_sequencer: directed plan steps plus random instructions
// against an arithmetic reference model; honours RFSEQ_LDI_FAST_EN when defined.
module tb_rf_op_sequencer;
    localparam int DW = 4;
    localparam int AW = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rf_op_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    rf_op_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: read address registered on the clock, data valid the cycle after.
    logic [DW-1:0] mem [16];
    logic [AW-1:0] ra1_q;
    logic [AW-1:0] ra2_q;
    always @(posedge clk) begin
        ra1_q <= bus.rf_rr1;
        ra2_q <= bus.rf_rr2;
        if (bus.rf_we) mem[bus.rf_wr] <= bus.rf_wdata;
    end
    assign bus.rf_rd1 = mem[ra1_q];
    assign bus.rf_rd2 = mem[ra2_q];

    logic [DW-1:0] ref_rf [16];
    logic          ref_carry;
    logic [DW-1:0] last_wdata;
    logic          fast_ldi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics with plain integer arithmetic; updates model file and carry.
    task automatic model(input logic [15:0] ins, output logic we_e, output logic err_e,
                         output logic [DW-1:0] res_e);
        int a, b, r, op;
        op    = int'(ins[15:12]);
        a     = int'(ref_rf[ins[7:4]]);
        b     = int'(ref_rf[ins[3:0]]);
        we_e  = 1'b1;
        err_e = 1'b0;
        r     = 0;
        case (op)
            0: we_e = 1'b0;
            1: begin r = a + b; ref_carry = (r >= 16); r = r % 16; end
            2: begin ref_carry = (a < b); r = (a - b + 16) % 16; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a;
            7: r = int'(ins[3:0]);
            8: begin ref_carry = (a >= 8); r = (a * 2) % 16; end
            9: begin ref_carry = (a % 2) == 1; r = a / 2; end
            default: begin we_e = 1'b0; err_e = 1'b1; end
        endcase
        res_e = r[DW-1:0];
        if (we_e) ref_rf[ins[11:8]] = res_e;
    endtask

    task automatic exec(input logic [15:0] ins);
        logic          we_e, err_e;
        logic [DW-1:0] res_e;
        int            lat, done_at, we_cnt;
        logic          ldi_short;
        model(ins, we_e, err_e, res_e);
        ldi_short = fast_ldi && (ins[15:12] == 4'd7);
        lat       = ldi_short ? 1 : 3;
        @(negedge clk);
        check("ready_before", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = 16'($urandom);
        done_at = 0;
        we_cnt  = 0;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("ready_low", bus.in_ready, 0);
                if (!ldi_short) begin
                    check("rr1", bus.rf_rr1, ins[7:4]);
                    check("rr2", bus.rf_rr2, ins[3:0]);
                end
            end
            if (bus.done === 1'b1 && done_at == 0) begin
                done_at    = n;
                last_wdata = bus.rf_wdata;
                check("we_at_done", bus.rf_we, we_e);
                check("err_at_done", bus.err, err_e);
                check("carry_at_done", bus.carry, ref_carry);
                if (we_e) begin
                    check("wr", bus.rf_wr, ins[11:8]);
                    check("wdata", bus.rf_wdata, res_e);
                end
            end
            if (bus.rf_we === 1'b1) we_cnt++;
        end
        check("done_latency", done_at, lat);
        check("we_count", we_cnt, we_e ? 1 : 0);
        check("ready_after", bus.in_ready, 1);
        check("done_dropped", bus.done, 0);
    endtask

    initial begin
        logic          we1, err1, we2, err2, c1, c2;
        logic [DW-1:0] res1, res2;
        logic [7:0]    rdy_v, done_v, we_v;
        logic [DW-1:0] wd3, wd7;
        logic          cy3, cy7;
        int            we_seen;

        checks    = 0;
        errors    = 0;
        ref_carry = 1'b0;
        last_wdata = '0;
`ifdef RFSEQ_LDI_FAST_EN
        fast_ldi = 1'b1;
`else
        fast_ldi = 1'b0;
`endif
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
        reset = 1'b1;
        #3;
        check("rst_ready", bus.in_ready, 1);
        check("rst_we", bus.rf_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_rr1", bus.rf_rr1, 0);
        check("rst_rr2", bus.rf_rr2, 0);
        check("rst_wr", bus.rf_wr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill every register via LDI so model and file agree.
        for (int r = 0; r < 16; r++)
            exec({4'h7, 4'(r), 4'h0, 4'($urandom_range(0, 15))});

        exec(16'h7309);
        check("plan_ldi_wdata", last_wdata, 4'h9);
        check("plan_ldi_carry", bus.carry, 0);
        exec(16'h710C);
        exec(16'h7207);
        exec(16'h1412);
        check("plan_add_wdata", last_wdata, 4'h3);
        check("plan_add_carry", bus.carry, 1);
        exec(16'h2521);
        check("plan_sub_wdata", last_wdata, 4'hB);
        check("plan_sub_carry", bus.carry, 1);
        exec(16'hE000);
        exec(16'h0000);
        exec(16'h700F);

        // Back-to-back: in_valid held, second instruction presented while busy.
        model(16'h1612, we1, err1, res1);
        c1 = ref_carry;
        model(16'h5712, we2, err2, res2);
        c2 = ref_carry;
        rdy_v = '0; done_v = '0; we_v = '0;
        wd3 = '0; wd7 = '0; cy3 = 1'b0; cy7 = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h1612;
        @(posedge clk);
        #1;
        bus.in_instr = 16'h5712;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            rdy_v[n-1]  = bus.in_ready;
            done_v[n-1] = bus.done;
            we_v[n-1]   = bus.rf_we;
            if (n == 3) begin wd3 = bus.rf_wdata; cy3 = bus.carry; end
            if (n == 7) begin wd7 = bus.rf_wdata; cy7 = bus.carry; end
            if (n == 5) bus.in_valid = 1'b0;
        end
        check("b2b_ready", rdy_v, 8'b1000_1000);
        check("b2b_done", done_v, 8'b0100_0100);
        check("b2b_we", we_v, 8'b0100_0100);
        check("b2b_wdata1", wd3, res1);
        check("b2b_wdata2", wd7, res2);
        check("b2b_carry1", cy3, c1);
        check("b2b_carry2", cy7, c2);

        // Reset while an ADD sits in EX: abandoned, no write, carry cleared.
        exec(16'h1412);
        check("pre_reset_carry", bus.carry, 1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h1812;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", bus.in_ready, 1);
        check("midrst_we", bus.rf_we, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_carry", bus.carry, 0);
        check("midrst_wdata", bus.rf_wdata, 0);
        @(negedge clk);
        reset = 1'b0;
        ref_carry = 1'b0;
        we_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) we_seen++;
        end
        check("midrst_no_write", we_seen, 0);
        check("midrst_ready_after", bus.in_ready, 1);

        for (int i = 0; i < 60; i++)
            exec(16'($urandom_range(0, 65535)));

        for (int r = 0; r < 16; r++)
            check("final_rf", mem[r], ref_rf[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
